// File: rtl/postproc_arbiter.sv
// Arbitrates the shared FPU post-processing datapath between the pipelined FMA unit and the
// iterative divsqrt unit; a finished divsqrt result is parked for at most MAXWAIT FMA cycles.
module postproc_arbiter #(
  parameter int NE      = 11,
  parameter int MAXWAIT = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          FlushDiv,
  input  logic          FmaValid,
  output logic          FmaReady,
  input  logic          DivDone,
  output logic          DivBusy,
  input  logic [NE+1:0] DivUeIn,
  input  logic          DivResSubnormIn,
  input  logic          DivSubnormShiftPosIn,
  output logic          FmaOp,
  output logic          DivOp,
  output logic [NE+1:0] DivUe,
  output logic          DivResSubnorm,
  output logic          DivSubnormShiftPos,
  output logic          PostProcValid
);

  localparam int CW = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;
  localparam logic [CW-1:0] MaxCnt = CW'(MAXWAIT);

  typedef enum logic {IDLE, PEND} state_t;

  typedef struct packed {
    logic [NE+1:0] ue;
    logic          subnorm;
    logic          shiftPos;
  } divRes_t;

  state_t        state, nextState;
  logic [CW-1:0] waitCnt, nextWaitCnt;
  divRes_t       divBuf, nextBuf, divIn, divSel;

  assign divIn = '{ue: DivUeIn, subnorm: DivResSubnormIn, shiftPos: DivSubnormShiftPosIn};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      waitCnt <= '0;
      divBuf  <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
      divBuf  <= nextBuf;
    end
  end

  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    nextBuf     = divBuf;
    FmaOp       = FmaValid;
    DivOp       = 1'b0;
    FmaReady    = 1'b1;
    DivBusy     = 1'b0;
    divSel      = DivDone ? divIn : '0;

    case (state)
      IDLE: begin
        if (DivDone && FmaValid) begin
          nextBuf     = divIn;
          nextWaitCnt = '0;
          nextState   = PEND;
        end else if (DivDone) begin
          DivOp = 1'b1;
        end
      end
      PEND: begin
        DivBusy = 1'b1;
        divSel  = divBuf;
        if (!FmaValid) begin
          DivOp       = 1'b1;
          nextState   = IDLE;
          nextWaitCnt = '0;
          nextBuf     = '0;
        end else if (waitCnt < MaxCnt) begin
          FmaOp       = 1'b1;
          nextWaitCnt = waitCnt + 1'b1;
        end else begin
          // Wait budget exhausted: divsqrt takes the datapath, FMA holds its operands
          DivOp       = 1'b1;
          FmaOp       = 1'b0;
          FmaReady    = 1'b0;
          nextState   = IDLE;
          nextWaitCnt = '0;
          nextBuf     = '0;
        end
      end
      default: nextState = IDLE;
    endcase

    if (FlushDiv) begin
      DivOp       = 1'b0;
      FmaOp       = FmaValid;
      FmaReady    = 1'b1;
      nextState   = IDLE;
      nextWaitCnt = '0;
      nextBuf     = '0;
    end

    // Held result must not leak out while reset is being applied
    if (!reset_n) begin
      DivOp    = 1'b0;
      FmaOp    = 1'b0;
      FmaReady = 1'b1;
      DivBusy  = 1'b0;
      divSel   = '0;
    end
  end

  assign DivUe              = divSel.ue;
  assign DivResSubnorm      = divSel.subnorm;
  assign DivSubnormShiftPos = divSel.shiftPos;
  assign PostProcValid      = FmaOp | DivOp;

  aDivDoneWhileBusy: assert property (@(posedge clk) disable iff (!reset_n)
    !(state == PEND && DivDone));
  aGrantExclusive: assert property (@(posedge clk) !(FmaOp && DivOp));

endmodule

// File: tb/tb_postproc_arbiter.sv
// Directed bench for postproc_arbiter with a small reference model for the random phase.
module tb_postproc_arbiter;
  localparam int NE = 11;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          FlushDiv, FmaValid, DivDone;
  logic [NE+1:0] DivUeIn;
  logic          DivResSubnormIn, DivSubnormShiftPosIn;
  logic          FmaReady, DivBusy, FmaOp, DivOp, PostProcValid;
  logic [NE+1:0] DivUe;
  logic          DivResSubnorm, DivSubnormShiftPos;

  int checks = 0;
  int errors = 0;

  postproc_arbiter #(.NE(NE), .MAXWAIT(3)) dut (
    .clk(clk), .reset_n(reset_n), .FlushDiv(FlushDiv), .FmaValid(FmaValid),
    .FmaReady(FmaReady), .DivDone(DivDone), .DivBusy(DivBusy), .DivUeIn(DivUeIn),
    .DivResSubnormIn(DivResSubnormIn), .DivSubnormShiftPosIn(DivSubnormShiftPosIn),
    .FmaOp(FmaOp), .DivOp(DivOp), .DivUe(DivUe), .DivResSubnorm(DivResSubnorm),
    .DivSubnormShiftPos(DivSubnormShiftPos), .PostProcValid(PostProcValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one cycle: inputs applied just after the edge, outputs sampled 1 unit later
  task automatic cyc(input logic fv, input logic dd, input logic [NE+1:0] ue,
                     input logic sub, input logic pos, input logic fl);
    @(posedge clk); #1;
    FmaValid = fv; DivDone = dd; DivUeIn = ue;
    DivResSubnormIn = sub; DivSubnormShiftPosIn = pos; FlushDiv = fl;
    #1;
  endtask

  task automatic chkIdleOuts(input string tag);
    chk({tag, "_fmaop"}, 32'(FmaOp), 0);
    chk({tag, "_divop"}, 32'(DivOp), 0);
    chk({tag, "_ppv"},   32'(PostProcValid), 0);
    chk({tag, "_busy"},  32'(DivBusy), 0);
    chk({tag, "_rdy"},   32'(FmaReady), 1);
    chk({tag, "_ue"},    32'(DivUe), 0);
    chk({tag, "_sub"},   32'(DivResSubnorm), 0);
    chk({tag, "_pos"},   32'(DivSubnormShiftPos), 0);
  endtask

  // reference model state for the random phase
  logic          mPend;
  int            mCnt;
  logic [NE+1:0] mBuf;
  int            doneCnt, issueCnt;

  initial begin
    reset_n = 1'b0; FlushDiv = 0; FmaValid = 0; DivDone = 0;
    DivUeIn = '0; DivResSubnormIn = 0; DivSubnormShiftPosIn = 0;
    repeat (2) @(posedge clk);
    #2;
    chkIdleOuts("rst");
    @(posedge clk); #1 reset_n = 1'b1;

    // T1 bypass
    cyc(0, 1, 13'h3F0, 1, 0, 0);
    chk("t1_divop", 32'(DivOp), 1);
    chk("t1_ue", 32'(DivUe), 32'h3F0);
    chk("t1_sub", 32'(DivResSubnorm), 1);
    chk("t1_fmaop", 32'(FmaOp), 0);
    chk("t1_ppv", 32'(PostProcValid), 1);
    chk("t1_busy", 32'(DivBusy), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chkIdleOuts("t1_after");

    // T2 forced issue after MAXWAIT FMA cycles
    for (int c = 0; c < 10; c++) begin
      cyc(1, c == 0, 13'h155, 0, 1, 0);
      chk($sformatf("t2_fmaop_c%0d", c), 32'(FmaOp), 32'(c != 4));
      chk($sformatf("t2_divop_c%0d", c), 32'(DivOp), 32'(c == 4));
      chk($sformatf("t2_rdy_c%0d", c), 32'(FmaReady), 32'(c != 4));
      chk($sformatf("t2_busy_c%0d", c), 32'(DivBusy), 32'(c >= 1 && c <= 4));
      chk($sformatf("t2_ue_c%0d", c), 32'(DivUe), (c <= 4) ? 32'h155 : 32'h0);
      if (c >= 1 && c <= 4) chk($sformatf("t2_pos_c%0d", c), 32'(DivSubnormShiftPos), 1);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chkIdleOuts("t2_after");

    // T3 FMA drops out while held
    cyc(1, 1, 13'h0AA, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t3_c1_fmaop", 32'(FmaOp), 1);
    chk("t3_c1_divop", 32'(DivOp), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_c2_divop", 32'(DivOp), 1);
    chk("t3_c2_ue", 32'(DivUe), 32'h0AA);
    chk("t3_c2_sub", 32'(DivResSubnorm), 1);
    chk("t3_c2_busy", 32'(DivBusy), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chkIdleOuts("t3_c3");

    // T4 flush of held result, FMA idle
    cyc(1, 1, 13'h1234, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t4_divop", 32'(DivOp), 0);
    chk("t4_ppv", 32'(PostProcValid), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chkIdleOuts("t4_after");

    // T4b flush in the forced-issue cycle leaves the FMA grant alone
    cyc(1, 1, 13'h0F0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("t4b_divop", 32'(DivOp), 0);
    chk("t4b_fmaop", 32'(FmaOp), 1);
    chk("t4b_rdy", 32'(FmaReady), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chkIdleOuts("t4b_after");

    // T5 reset while held
    cyc(1, 1, 13'h077, 1, 1, 0);
    @(posedge clk); #1;
    reset_n = 1'b0; FmaValid = 0; DivDone = 0; DivUeIn = '0;
    DivResSubnormIn = 0; DivSubnormShiftPosIn = 0;
    #1;
    chk("t5_nopulse", 32'(DivOp), 0);
    @(posedge clk); #2;
    chkIdleOuts("t5_rst");
    @(posedge clk); #1 reset_n = 1'b1;
    #1;
    chkIdleOuts("t5_rel");

    // T6 random traffic against the reference model
    mPend = 0; mCnt = 0; mBuf = '0; doneCnt = 0; issueCnt = 0;
    for (int i = 0; i < 400; i++) begin
      logic fv, dd, eFma, eDiv;
      logic [NE+1:0] ue, eUe;
      fv = ($urandom_range(0, 3) != 0);
      dd = !mPend && ($urandom_range(0, 2) == 0);
      ue = 13'($urandom_range(1, 8191));
      cyc(fv, dd, ue, 0, 0, 0);
      if (!mPend) begin
        eFma = fv; eDiv = dd && !fv; eUe = dd ? ue : '0;
      end else begin
        eUe = mBuf;
        if (!fv) begin eFma = 0; eDiv = 1; end
        else if (mCnt < 3) begin eFma = 1; eDiv = 0; end
        else begin eFma = 0; eDiv = 1; end
      end
      chk($sformatf("t6_fmaop_%0d", i), 32'(FmaOp), 32'(eFma));
      chk($sformatf("t6_divop_%0d", i), 32'(DivOp), 32'(eDiv));
      chk($sformatf("t6_excl_%0d", i), 32'(FmaOp & DivOp), 0);
      if (eDiv) chk($sformatf("t6_ue_%0d", i), 32'(DivUe), 32'(eUe));
      doneCnt += int'(dd);
      issueCnt += int'(DivOp);
      if (!mPend && dd && fv) begin mPend = 1; mCnt = 0; mBuf = ue; end
      else if (mPend) begin
        if (!fv || mCnt == 3) mPend = 0;
        else mCnt++;
      end
    end
    repeat (2) begin
      cyc(0, 0, 0, 0, 0, 0);
      issueCnt += int'(DivOp);
    end
    chk("t6_issue_count", 32'(issueCnt), 32'(doneCnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
